pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Registered program-counter and branch sequencer for the MIPS core. It holds the PC and the N/Z/V status flags and resolves the custom control-flow ops: bmn, brz, bz, jmor, jalm and jspal. Memory-indirect targets are fetched through a request/valid handshake, so they may take more than one cycle. It sits between the decode/ALU stage (op, flags, operands) and instruction fetch (pc), and returns link values to the register file.

## Interface
Parameters:
- ADDR_W, 32, width of PC, operands and memory data.
- RESET_PC, 0, PC value after reset.
- STEP, 4, sequential increment; must be a power of two ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold request from the pipeline; honoured only in IDLE.
- br_op  in  3  000 none, 001 bmn, 010 brz, 011 bz, 100 jmor, 101 jalm, 110 jspal, 111 reserved (treated as none).
- flag_we  in  1  latch n_in/z_in/v_in into the flag register.
- n_in, z_in, v_in  in  1 each  ALU status.
- reg_s  in  ADDR_W  register operand: brz target, and memory address for the indirect ops.
- j_diraddr  in  ADDR_W  bz direct target.
- mem_req  out  1  indirect-target read request.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  ADDR_W  read data.
- mem_valid  in  1  read data valid.
- pc  out  ADDR_W  current PC (register).
- flags  out  3  {v,n,z} flag register.
- redirect  out  1  next PC is not pc+STEP.
- busy  out  1  FSM in WAIT_MEM.
- link_we  out  1  link write strobe.
- link_data  out  ADDR_W  link value.

## Operation
- Flags are registered. Branch decisions use the current register contents. A flag_we in the same cycle as a branch affects only later instructions.
- Target alignment: the low log2(STEP) bits of every non-sequential target are forced to 0.
- FSM states are IDLE and WAIT_MEM. Captured state: op_q, link_q = pc+STEP, addr_q = reg_s.
- IDLE with stall=1: pc holds, no request, redirect=0.
- IDLE, op none/reserved: pc ← pc+STEP.
- IDLE, bz: pc ← z ? j_diraddr : pc+STEP; redirect=z.
- IDLE, brz: pc ← z ? reg_s : pc+STEP; redirect=z.
- IDLE, bmn with n=0: pc ← pc+STEP. No memory read is issued.
- IDLE, bmn with n=1, or jmor/jalm/jspal:
  - mem_req=1 and mem_addr=reg_s in the same cycle.
  - Capture op_q, link_q and addr_q, then go to WAIT_MEM. pc holds.
- WAIT_MEM:
  - mem_req stays 1 and mem_addr=addr_q, stable, until mem_valid.
  - stall and br_op are ignored.
  - On mem_valid: pc ← mem_rdata, redirect=1, return to IDLE.
  - If op_q is jalm or jspal: link_we=1 for exactly that cycle, with link_data=link_q.
- mem_valid is sampled only in WAIT_MEM. A mem_valid seen in IDLE is ignored.
- Arithmetic is modulo 2^ADDR_W. pc+STEP wraps silently at the top of the address space.
- rst, in any state including mid-WAIT_MEM:
  - pc=RESET_PC, flags=0, state=IDLE.
  - mem_req, redirect, busy and link_we all 0. link_data=0.
  - Any outstanding read is abandoned.

## Timing
- Direct ops (none, bz, brz, bmn with n=0) take 1 cycle. The new pc is visible the cycle after the op is presented.
- redirect is combinational in the deciding cycle: the IDLE cycle for direct ops, the mem_valid cycle for indirect ops.
- Indirect ops take 1 + k cycles, where k ≥ 1 is the number of WAIT_MEM cycles up to and including the mem_valid cycle. The minimum is 2 cycles.
- busy=1 exactly while in WAIT_MEM. Upstream must hold the next op until busy=0.
- Flag latch latency is 1 cycle.

## Structure
- Shared package `pc_seq_pkg` holds:
  - br_op encodings as localparams (OP_NONE, OP_BMN, OP_BRZ, OP_BZ, OP_JMOR, OP_JALM, OP_JSPAL).
  - State encodings (S_IDLE, S_WAIT_MEM).
  - A function is_indirect(op, n).
- One sub-module, `pc_target_mux`: combinational selection of next PC and redirect from op, flags, operands and FSM state, with alignment masking. The FSM, PC, flag and capture registers stay in the top.

## Test plan
- Reset, then 3 idle cycles with br_op=000 → pc 0→4→8→12, redirect=0, flags=000.
- z latched to 1, then bz with j_diraddr=0x103 → redirect=1 that cycle, next pc=0x100. Repeat with z=0 → pc+4.
- Same cycle: flag_we with n_in=1 and bmn → no request, pc+4. Next bmn, reg_s=0x40, mem_valid after 3 cycles with rdata=0x200 → mem_req high 4 cycles, addr=0x40 stable, busy 3 cycles, then pc=0x200.
- jalm at pc=0x10 with mem_valid one cycle after the request → link_we single pulse with link_data=0x14, pc=rdata. Changing br_op and stall during WAIT_MEM has no effect.
- rst asserted during WAIT_MEM, then mem_valid arrives → pc=RESET_PC, no redirect, no link_we, mem_req=0.
- ADDR_W=16, STEP=2, pc=0xFFFE, op none → pc=0x0000. brz to 0x1235 → pc=0x1234.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: branch opcodes, FSM states
// and the decode of which ops fetch their target through memory.
package pc_seq_pkg;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_BMN   = 3'b001;
    localparam logic [2:0] OP_BRZ   = 3'b010;
    localparam logic [2:0] OP_BZ    = 3'b011;
    localparam logic [2:0] OP_JMOR  = 3'b100;
    localparam logic [2:0] OP_JALM  = 3'b101;
    localparam logic [2:0] OP_JSPAL = 3'b110;

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT_MEM = 1'b1;

    // bmn only goes to memory when the negative flag is set.
    function automatic logic is_indirect(input logic [2:0] op, input logic n);
        return ((op == OP_BMN) && n) || (op == OP_JMOR) || (op == OP_JALM) ||
               (op == OP_JSPAL);
    endfunction

    function automatic logic is_link(input logic [2:0] op);
        return (op == OP_JALM) || (op == OP_JSPAL);
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC and redirect selection; non-sequential targets are aligned
// down to a STEP boundary.
module pc_target_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STEP   = 4
) (
    input  logic [0:0]        state,
    input  logic [2:0]        op,
    input  logic              stall,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] reg_s,
    input  logic [ADDR_W-1:0] j_diraddr,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN  = ~(STEP_V - ADDR_W'(1));

    logic [ADDR_W-1:0] seq_pc;

    assign seq_pc = pc + STEP_V;

    always_comb begin
        next_pc  = seq_pc;
        redirect = 1'b0;
        if (state == S_WAIT_MEM) begin
            next_pc = pc;
            if (mem_valid) begin
                next_pc  = mem_rdata & ALIGN;
                redirect = 1'b1;
            end
        end else if (stall || is_indirect(op, flag_n)) begin
            next_pc = pc;
        end else begin
            case (op)
                OP_BZ: begin
                    if (flag_z) begin
                        next_pc  = j_diraddr & ALIGN;
                        redirect = 1'b1;
                    end
                end
                OP_BRZ: begin
                    if (flag_z) begin
                        next_pc  = reg_s & ALIGN;
                        redirect = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, N/Z/V flags and the IDLE/WAIT_MEM sequencer for memory-indirect
// control-flow ops, with link write-back for jalm/jspal.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       STEP     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [2:0]        br_op,
    input  logic              flag_we,
    input  logic              n_in,
    input  logic              z_in,
    input  logic              v_in,
    input  logic [ADDR_W-1:0] reg_s,
    input  logic [ADDR_W-1:0] j_diraddr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        flags,
    output logic              redirect,
    output logic              busy,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    logic [0:0]        state_q;
    logic [2:0]        op_q;
    logic [2:0]        flags_q;
    logic [ADDR_W-1:0] pc_q, link_q, addr_q;
    logic [ADDR_W-1:0] next_pc;
    logic              mux_redirect;
    logic              start;

    // flags_q is {v, n, z}
    assign start = (state_q == S_IDLE) && !stall && is_indirect(br_op, flags_q[1]);
    assign pc    = pc_q;
    assign flags = flags_q;

    pc_target_mux #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_target_mux (
        .state     (state_q),
        .op        (br_op),
        .stall     (stall),
        .flag_n    (flags_q[1]),
        .flag_z    (flags_q[0]),
        .pc        (pc_q),
        .reg_s     (reg_s),
        .j_diraddr (j_diraddr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .next_pc   (next_pc),
        .redirect  (mux_redirect)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            flags_q <= '0;
            op_q    <= OP_NONE;
            link_q  <= '0;
            addr_q  <= '0;
        end else begin
            pc_q <= next_pc;
            if (flag_we) begin
                flags_q <= {v_in, n_in, z_in};
            end
            if (start) begin
                state_q <= S_WAIT_MEM;
                op_q    <= br_op;
                link_q  <= pc_q + STEP_V;
                addr_q  <= reg_s;
            end else if ((state_q == S_WAIT_MEM) && mem_valid) begin
                state_q <= S_IDLE;
            end
        end
    end

    // Reset silences every strobe combinationally so an in-flight read is dropped.
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = reg_s;
        redirect  = 1'b0;
        busy      = 1'b0;
        link_we   = 1'b0;
        link_data = '0;
        if (!rst) begin
            redirect  = mux_redirect;
            link_data = link_q;
            if (state_q == S_WAIT_MEM) begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                busy     = 1'b1;
                link_we  = mem_valid && is_link(op_q);
            end else begin
                mem_req = start;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: the driver queues the expected per-cycle outputs, a negedge
// monitor pops and compares them against a 32-bit/STEP=4 and a 16-bit/STEP=2 instance.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_b, stall, flag_we, n_in, z_in, v_in, mem_valid;
    logic [2:0]  br_op;
    logic [31:0] reg_s, j_diraddr, mem_rdata;

    logic        a_mem_req, a_redirect, a_busy, a_link_we;
    logic [31:0] a_mem_addr, a_pc, a_link_data;
    logic [2:0]  a_flags;
    logic        b_mem_req, b_redirect, b_busy, b_link_we;
    logic [15:0] b_mem_addr, b_pc, b_link_data;
    logic [2:0]  b_flags;

    pc_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .STEP     (4)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_op     (br_op),
        .flag_we   (flag_we),
        .n_in      (n_in),
        .z_in      (z_in),
        .v_in      (v_in),
        .reg_s     (reg_s),
        .j_diraddr (j_diraddr),
        .mem_req   (a_mem_req),
        .mem_addr  (a_mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .pc        (a_pc),
        .flags     (a_flags),
        .redirect  (a_redirect),
        .busy      (a_busy),
        .link_we   (a_link_we),
        .link_data (a_link_data)
    );

    pc_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'hFFFE),
        .STEP     (2)
    ) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .stall     (stall),
        .br_op     (br_op),
        .flag_we   (flag_we),
        .n_in      (n_in),
        .z_in      (z_in),
        .v_in      (v_in),
        .reg_s     (reg_s[15:0]),
        .j_diraddr (j_diraddr[15:0]),
        .mem_req   (b_mem_req),
        .mem_addr  (b_mem_addr),
        .mem_rdata (mem_rdata[15:0]),
        .mem_valid (mem_valid),
        .pc        (b_pc),
        .flags     (b_flags),
        .redirect  (b_redirect),
        .busy      (b_busy),
        .link_we   (b_link_we),
        .link_data (b_link_data)
    );

    typedef struct {
        bit          sel_b;
        string       name;
        logic [31:0] pc;
        logic [2:0]  flags;
        logic        redirect;
        logic        mem_req;
        logic [31:0] mem_addr;
        logic        busy;
        logic        link_we;
        logic [31:0] link_data;
        bit          chk_addr;
        bit          chk_link;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s.%s: got 0x%0h, required 0x%0h", nm, fld, act, req);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [31:0] pc_v,
                                input logic [2:0] fl, input logic rd, input logic rq,
                                input logic bz_v);
        exp_t e;
        e.sel_b     = 1'b0;
        e.name      = nm;
        e.pc        = pc_v;
        e.flags     = fl;
        e.redirect  = rd;
        e.mem_req   = rq;
        e.mem_addr  = '0;
        e.busy      = bz_v;
        e.link_we   = 1'b0;
        e.link_data = '0;
        e.chk_addr  = rq;
        e.chk_link  = 1'b0;
        return e;
    endfunction

    task automatic apply(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        stall     = 1'b0;
        br_op     = OP_NONE;
        flag_we   = 1'b0;
        n_in      = 1'b0;
        z_in      = 1'b0;
        v_in      = 1'b0;
        mem_valid = 1'b0;
        reg_s     = '0;
        j_diraddr = '0;
        mem_rdata = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                cmp(e.name, "pc", e.sel_b ? {16'h0, b_pc} : a_pc, e.pc);
                cmp(e.name, "flags", {29'h0, e.sel_b ? b_flags : a_flags}, {29'h0, e.flags});
                cmp(e.name, "redirect", {31'h0, e.sel_b ? b_redirect : a_redirect},
                    {31'h0, e.redirect});
                cmp(e.name, "mem_req", {31'h0, e.sel_b ? b_mem_req : a_mem_req},
                    {31'h0, e.mem_req});
                cmp(e.name, "busy", {31'h0, e.sel_b ? b_busy : a_busy}, {31'h0, e.busy});
                cmp(e.name, "link_we", {31'h0, e.sel_b ? b_link_we : a_link_we},
                    {31'h0, e.link_we});
                if (e.chk_addr)
                    cmp(e.name, "mem_addr", e.sel_b ? {16'h0, b_mem_addr} : a_mem_addr,
                        e.mem_addr);
                if (e.chk_link)
                    cmp(e.name, "link_data", e.sel_b ? {16'h0, b_link_data} : a_link_data,
                        e.link_data);
            end
        end
    end

    initial begin : driver
        exp_t e;
        quiet();
        rst   = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        e = mk("reset", 32'h0, 3'b000, 0, 0, 0); e.chk_link = 1; apply(e);
        rst = 1'b0;

        e = mk("seq0", 32'h0, 3'b000, 0, 0, 0); apply(e);
        e = mk("seq4", 32'h4, 3'b000, 0, 0, 0); apply(e);
        e = mk("seq8", 32'h8, 3'b000, 0, 0, 0); apply(e);

        flag_we = 1; z_in = 1;
        e = mk("setz", 32'hC, 3'b000, 0, 0, 0); apply(e);
        quiet(); br_op = OP_BZ; j_diraddr = 32'h103;
        e = mk("bz_taken", 32'h10, 3'b001, 1, 0, 0); apply(e);
        quiet(); flag_we = 1;
        e = mk("clrz", 32'h100, 3'b001, 0, 0, 0); apply(e);
        quiet(); br_op = OP_BZ; j_diraddr = 32'h103;
        e = mk("bz_not", 32'h104, 3'b000, 0, 0, 0); apply(e);

        // flag_we together with bmn: n not yet visible, so no read
        quiet(); flag_we = 1; n_in = 1; br_op = OP_BMN; reg_s = 32'h40;
        e = mk("bmn_n0", 32'h108, 3'b000, 0, 0, 0); apply(e);
        quiet(); br_op = OP_BMN; reg_s = 32'h40;
        e = mk("bmn_req", 32'h10C, 3'b010, 0, 1, 0); e.mem_addr = 32'h40; apply(e);
        quiet(); reg_s = 32'h99;
        e = mk("bmn_w1", 32'h10C, 3'b010, 0, 1, 1); e.mem_addr = 32'h40; apply(e);
        e = mk("bmn_w2", 32'h10C, 3'b010, 0, 1, 1); e.mem_addr = 32'h40; apply(e);
        mem_valid = 1; mem_rdata = 32'h200;
        e = mk("bmn_w3", 32'h10C, 3'b010, 1, 1, 1); e.mem_addr = 32'h40; apply(e);
        quiet(); mem_valid = 1; mem_rdata = 32'h777;
        e = mk("idle_valid", 32'h200, 3'b010, 0, 0, 0); apply(e);

        quiet(); br_op = OP_JMOR; reg_s = 32'h80;
        e = mk("jmor_req", 32'h204, 3'b010, 0, 1, 0); e.mem_addr = 32'h80; apply(e);
        quiet(); mem_valid = 1; mem_rdata = 32'h12;
        e = mk("jmor_w", 32'h204, 3'b010, 1, 1, 1); e.mem_addr = 32'h80; apply(e);

        quiet(); br_op = OP_JALM; reg_s = 32'h50;
        e = mk("jalm_req", 32'h10, 3'b010, 0, 1, 0); e.mem_addr = 32'h50; apply(e);
        quiet(); br_op = OP_BZ; stall = 1; j_diraddr = 32'h300; reg_s = 32'h60;
        mem_valid = 1; mem_rdata = 32'h400;
        e = mk("jalm_w", 32'h10, 3'b010, 1, 1, 1); e.mem_addr = 32'h50;
        e.link_we = 1; e.link_data = 32'h14; e.chk_link = 1; apply(e);
        quiet(); stall = 1;
        e = mk("stall", 32'h400, 3'b010, 0, 0, 0); apply(e);
        quiet();
        e = mk("unstall", 32'h400, 3'b010, 0, 0, 0); apply(e);
        quiet(); stall = 1; br_op = OP_JSPAL; reg_s = 32'h20;
        e = mk("stall_jspal", 32'h404, 3'b010, 0, 0, 0); apply(e);

        quiet(); br_op = OP_JSPAL; reg_s = 32'h20;
        e = mk("jspal_req", 32'h404, 3'b010, 0, 1, 0); e.mem_addr = 32'h20; apply(e);
        quiet();
        e = mk("jspal_w1", 32'h404, 3'b010, 0, 1, 1); e.mem_addr = 32'h20; apply(e);
        rst = 1; mem_valid = 1; mem_rdata = 32'h500;
        e = mk("rst_wait", 32'h404, 3'b010, 0, 0, 0); e.chk_link = 1; apply(e);
        rst = 0;
        e = mk("post_rst", 32'h0, 3'b000, 0, 0, 0); apply(e);
        quiet();
        e = mk("post_rst2", 32'h4, 3'b000, 0, 0, 0); apply(e);

        // 16-bit instance: wrap at the top and STEP=2 alignment
        e = mk("b_reset", 32'hFFFE, 3'b000, 0, 0, 0); e.sel_b = 1; e.chk_link = 1; apply(e);
        rst_b = 0; flag_we = 1; z_in = 1;
        e = mk("b_wrap", 32'hFFFE, 3'b000, 0, 0, 0); e.sel_b = 1; apply(e);
        quiet(); br_op = OP_BRZ; reg_s = 32'h1235;
        e = mk("b_brz", 32'h0, 3'b001, 1, 0, 0); e.sel_b = 1; apply(e);
        quiet();
        e = mk("b_after", 32'h1234, 3'b001, 0, 0, 0); e.sel_b = 1; apply(e);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
